// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parameterised register file.
package regfile_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NUM_RD = 2;

  // Address width for a given depth; never narrower than one bit.
  function automatic int rf_addr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dffe_word.sv
// One storage word: enabled register with asynchronous active-high clear.
module dffe_word
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Power-up value of zero so simulation starts from a cleared file.
  logic [WIDTH-1:0] word_q = '0;
  logic [WIDTH-1:0] word_d;

  // Load new data only when this word is selected by the write decode.
  always_comb begin
    word_d = word_q;
    if (en) word_d = d;
  end

  // Clear is asynchronous so the file empties without waiting for a clock.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) word_q <= '0;
    else     word_q <= word_d;
  end

  assign q = word_q;

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file: one write port, NUM_RD combinational read
// ports, optional write-to-read forwarding and optional hardwired r0.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_addr_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    we,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data
);

  // First physically stored word; r0 has no storage when it is hardwired.
  localparam int FIRST = (ZERO_REG != 0) ? 1 : 0;
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic                   wr_ok;
  logic [DEPTH-1:FIRST]   wr_onehot;
  logic [WIDTH-1:0]       word    [DEPTH];
  logic [WIDTH-1:0]       rd_word [NUM_RD];

  // A write counts only in range, outside reset and not aimed at a hardwired r0;
  // the same qualifier gates forwarding so ignored writes never leak to reads.
  always_comb begin
    wr_ok = we && !clr && ({1'b0, wr_addr} < DEPTH_LIM)
            && !((ZERO_REG != 0) && (wr_addr == '0));
  end

  // One-hot write decode into the word enables.
  always_comb begin
    wr_onehot = '0;
    for (int i = FIRST; i < DEPTH; i++) begin
      wr_onehot[i] = wr_ok && (wr_addr == AW'(i));
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if (i < FIRST) begin : g_zero
      assign word[i] = '0;
    end else begin : g_reg
      dffe_word #(.WIDTH(WIDTH)) u_word (
        .clk (clk),
        .clr (clr),
        .en  (wr_onehot[i]),
        .d   (wr_data),
        .q   (word[i])
      );
    end
  end

  // Per-port DEPTH:1 mux; out-of-range addresses match nothing and read zero.
  // The forwarding compare comes after the mux so it overrides stored data.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_word[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr[p*AW +: AW] == AW'(i)) rd_word[p] = word[i];
      end
      if ((BYPASS != 0) && wr_ok && (rd_addr[p*AW +: AW] == wr_addr)) begin
        rd_word[p] = wr_data;
      end
    end
  end

  // Pack the per-port words onto the flat output bus.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p*WIDTH +: WIDTH] = rd_word[p];
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: instance A (32 deep, 4 read ports, forwarding,
// hardwired r0) and instance B (20 deep, 2 read ports, no forwarding,
// writable r0) share the write side and reset.
module tb_regfile_param;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         we = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic [19:0]  rd_addr_a = '0;
  logic [127:0] rd_data_a;
  logic [9:0]   rd_addr_b = '0;
  logic [63:0]  rd_data_b;

  always #5 clk = ~clk;

  regfile_param #(.WIDTH(32), .DEPTH(32), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .clr(clr), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a)
  );

  regfile_param #(.WIDTH(32), .DEPTH(20), .NUM_RD(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .clr(clr), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b)
  );

  typedef struct {
    bit          is_b;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [20];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] exp_a(input logic [4:0] ra);
    if (we && !clr && wr_addr != 5'd0 && ra == wr_addr) return wr_data;
    if (ra == 5'd0) return 32'h0;
    return mem_a[ra];
  endfunction

  function automatic logic [31:0] exp_b(input logic [4:0] ra);
    if (ra >= 5'd20) return 32'h0;
    return mem_b[ra];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem_a[i] = '0;
    for (int i = 0; i < 20; i++) mem_b[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!clr && we) begin
      if (wr_addr != 5'd0) mem_a[wr_addr] = wr_data;
      if (wr_addr < 5'd20) mem_b[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic set_wr(input logic w, input logic [4:0] a, input logic [31:0] d);
    we = w; wr_addr = a; wr_data = d;
  endtask

  task automatic set_rd(input logic [4:0] a0, a1, a2, a3, b0, b1);
    rd_addr_a = {a3, a2, a1, a0};
    rd_addr_b = {b1, b0};
  endtask

  task automatic push_expected();
    for (int p = 0; p < 4; p++) sb.push_back('{is_b: 1'b0, port: p, val: exp_a(rd_addr_a[p*5 +: 5])});
    for (int p = 0; p < 2; p++) sb.push_back('{is_b: 1'b1, port: p, val: exp_b(rd_addr_b[p*5 +: 5])});
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] act;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin set_rd(0, 5, 31, 7, 0, 19); set_wr(0, 0, 0); end
        1: begin clr = 1'b1; clear_model(); set_wr(1, 5, 32'h1111_1111); set_rd(5, 5, 5, 5, 5, 5); end
        2: tick();
        default: begin set_wr(0, 0, 0); clr = 1'b0; end
      endcase
      push_expected(); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        act = e.is_b ? rd_data_b[e.port*32 +: 32] : rd_data_a[e.port*32 +: 32];
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL reset s%0d %s port%0d got %h want %h", s, e.is_b ? "b" : "a", e.port, act, e.val);
        end
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e; logic [31:0] act;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin clr = 1'b1; clear_model(); end
        1: begin clr = 1'b0; set_wr(1, 5, 32'hDEAD_BEEF); set_rd(5, 0, 5, 0, 5, 0); end
        default: begin tick(); set_wr(0, 0, 0); end
      endcase
      push_expected(); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        act = e.is_b ? rd_data_b[e.port*32 +: 32] : rd_data_a[e.port*32 +: 32];
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL write_read s%0d %s port%0d got %h want %h", s, e.is_b ? "b" : "a", e.port, act, e.val);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    exp_t e; logic [31:0] act;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin set_wr(1, 0, 32'h1234_5678); set_rd(0, 0, 0, 0, 0, 0); end
        1: begin tick(); set_wr(0, 0, 0); end
        default: tick();
      endcase
      push_expected(); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        act = e.is_b ? rd_data_b[e.port*32 +: 32] : rd_data_a[e.port*32 +: 32];
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL zero_reg s%0d %s port%0d got %h want %h", s, e.is_b ? "b" : "a", e.port, act, e.val);
        end
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e; logic [31:0] act;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin set_wr(1, 7, 32'h1); set_rd(7, 7, 7, 7, 7, 7); end
        1: begin tick(); set_wr(1, 7, 32'hA5A5_A5A5); end
        default: begin tick(); set_wr(0, 0, 0); end
      endcase
      push_expected(); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        act = e.is_b ? rd_data_b[e.port*32 +: 32] : rd_data_a[e.port*32 +: 32];
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL bypass s%0d %s port%0d got %h want %h", s, e.is_b ? "b" : "a", e.port, act, e.val);
        end
      end
    end
  endtask

  task automatic test_clear_async();
    exp_t e; logic [31:0] act;
    for (int i = 1; i < 32; i++) begin
      set_wr(1, 5'(i), 32'(i * 3));
      tick();
    end
    for (int s = 0; s < 11; s++) begin
      if (s < 8) begin
        set_wr(0, 0, 0);
        set_rd(5'(4*s), 5'(4*s+1), 5'(4*s+2), 5'(4*s+3), 5'(2*s+1), 5'(2*s+4));
      end else if (s == 8) begin
        set_wr(1, 4, 32'h777); set_rd(4, 9, 31, 1, 4, 19);
      end else if (s == 9) begin
        #2; clr = 1'b1; clear_model();
      end else begin
        tick(); clr = 1'b0; set_wr(0, 0, 0);
      end
      push_expected(); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        act = e.is_b ? rd_data_b[e.port*32 +: 32] : rd_data_a[e.port*32 +: 32];
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL clear_async s%0d %s port%0d got %h want %h", s, e.is_b ? "b" : "a", e.port, act, e.val);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    exp_t e; logic [31:0] act;
    for (int i = 0; i < 20; i++) begin
      set_wr(1, 5'(i), 32'hB000_0000 + 32'(i));
      tick();
    end
    for (int s = 0; s < 13; s++) begin
      if (s == 0) begin
        set_wr(1, 25, 32'h0000_FFFF); set_rd(25, 25, 0, 1, 25, 19);
      end else if (s == 1) begin
        tick(); set_wr(0, 0, 0); set_rd(25, 24, 31, 20, 25, 31);
      end else if (s == 2) begin
        set_wr(1, 31, 32'h0BAD_0BAD); set_rd(31, 3, 4, 5, 31, 20);
      end else begin
        if (s == 3) begin tick(); set_wr(0, 0, 0); end
        set_rd(5'(2*(s-3)), 5'(2*(s-3)+1), 25, 31, 5'(2*(s-3)), 5'(2*(s-3)+1));
      end
      push_expected(); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        act = e.is_b ? rd_data_b[e.port*32 +: 32] : rd_data_a[e.port*32 +: 32];
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL out_of_range s%0d %s port%0d got %h want %h", s, e.is_b ? "b" : "a", e.port, act, e.val);
        end
      end
    end
  endtask

  task automatic test_multi_port();
    exp_t e; logic [31:0] act;
    set_wr(1, 9, 32'h0000_CAFE);  tick();
    set_wr(1, 10, 32'h0000_BEEF); tick();
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin set_wr(0, 0, 0); set_rd(9, 9, 10, 9, 9, 10); end
        1: set_wr(1, 10, 32'h0000_1234);
        default: begin tick(); set_wr(0, 0, 0); end
      endcase
      push_expected(); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        act = e.is_b ? rd_data_b[e.port*32 +: 32] : rd_data_a[e.port*32 +: 32];
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL multi_port s%0d %s port%0d got %h want %h", s, e.is_b ? "b" : "a", e.port, act, e.val);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [31:0] act;
    for (int n = 0; n < 40; n++) begin
      set_wr(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
      set_rd(5'($urandom_range(0, 31)), wr_addr, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             wr_addr, 5'($urandom_range(0, 31)));
      push_expected(); #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        act = e.is_b ? rd_data_b[e.port*32 +: 32] : rd_data_a[e.port*32 +: 32];
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL back_to_back n%0d %s port%0d got %h want %h", n, e.is_b ? "b" : "a", e.port, act, e.val);
        end
      end
      tick();
    end
    set_wr(0, 0, 0);
  endtask

  initial begin
    clear_model();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_clear_async();
    test_out_of_range();
    test_multi_port();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32: number of registers, 2..256, not required to be a power of two.
REQ-003 SHALL have parameter NUM_RD, default 2: number of independent read ports, 1..4.
REQ-004 SHALL have parameter BYPASS, default 1: 1 forwards same-cycle write data to reads, 0 does not.
REQ-005 SHALL have parameter ZERO_REG, default 1: 1 hardwires register 0 to zero, 0 makes it writable.
REQ-006 SHALL have derived localparam AW = max(1, clog2(DEPTH)): address width.
REQ-007 SHALL have port clk, input, 1: clock, rising-edge active.
REQ-008 SHALL have port clr, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have port we, input, 1: write enable.
REQ-010 SHALL have port wr_addr, input, AW: write address.
REQ-011 SHALL have port wr_data, input, WIDTH: write data.
REQ-012 SHALL have port rd_addr, input, NUM_RD*AW: read addresses, with port i at bits [i*AW +: AW].
REQ-013 SHALL have port rd_data, output, NUM_RD*WIDTH: read data, with port i at bits [i*WIDTH +: WIDTH].

Function
REQ-014 SHALL write wr_data into register wr_addr on the rising clk edge when we=1, clr=0, wr_addr<DEPTH and not (ZERO_REG=1 and wr_addr=0).
REQ-015 SHALL ignore a write, leaving all state unchanged, when wr_addr>=DEPTH or (ZERO_REG=1 and wr_addr=0).
REQ-016 SHALL drive each rd_data port combinationally from the stored register at its rd_addr, with zero sequential latency.
REQ-017 SHALL return all zeros on a read port whose address is >=DEPTH, or is 0 when ZERO_REG=1.
REQ-018 SHALL, when BYPASS=1, drive wr_data on every read port whose rd_addr equals wr_addr in a cycle where the write is accepted per REQ-014, regardless of the stored value.
REQ-019 SHALL, when BYPASS=0, return the pre-edge stored value for a same-cycle read and write to one address, with the new value visible from the next cycle.
REQ-020 SHALL never forward an ignored write (REQ-015) to any read port.
REQ-021 SHALL serve any number of read ports addressing the same register identically and independently.
REQ-022 SHALL leave rd_data unregistered; it settles within the same cycle as a change on rd_addr, wr_addr, wr_data, we or clr.

Reset
REQ-023 SHALL clear every register to 0 immediately on clr rising, independent of clk.
REQ-024 SHALL hold all registers at 0 and accept no write while clr=1, including when we=1 coincides with a clk edge.
REQ-025 SHALL suppress bypass while clr=1, so all rd_data outputs read 0.
REQ-026 SHALL, when clr asserts during a write cycle, discard that write entirely.
REQ-027 SHALL power up in simulation with all registers at 0.

Structure
REQ-028 SHALL place the default constants (RF_WIDTH=32, RF_DEPTH=32, RF_NUM_RD=2) in the shared package regfile_pkg.
REQ-029 SHALL build each storage word from one sub-module, dffe_word: a WIDTH-bit register with enable and asynchronous active-high clear, instantiated DEPTH times, or DEPTH-1 times when ZERO_REG=1.
REQ-030 SHALL implement the write decode as a one-hot enable vector driving the dffe_word enables.
REQ-031 SHALL implement read selection as one DEPTH:1 multiplexer per read port, followed by the bypass comparator.

Verification
REQ-032 SHALL cover this scenario: after clr pulse, write 0xDEADBEEF to r5, then next cycle read r5 on port0 and r0 on port1 -> 0xDEADBEEF and 0x00000000.
REQ-033 SHALL cover this scenario: write 0x12345678 to r0 with ZERO_REG=1 -> r0 reads 0 on all ports in this and all later cycles.
REQ-034 SHALL cover this scenario: with r7=0x1, same-cycle write 0xA5A5A5A5 to r7 while reading r7 -> 0xA5A5A5A5 that cycle with BYPASS=1, or 0x1 that cycle then 0xA5A5A5A5 next cycle with BYPASS=0.
REQ-035 SHALL cover this scenario: fill r1..r31 with value index*3, then assert clr mid-cycle without clk -> all ports read 0 immediately, and a write held with we=1 during clr is lost.
REQ-036 SHALL cover this scenario: with DEPTH=20, write 0xFFFF to address 25 and read address 25 -> read 0, and no register r0..r19 changes.
REQ-037 SHALL cover this scenario: with NUM_RD=4, all ports read r9=0xCAFE while port2 reads r10=0xBEEF -> ports 0, 1 and 3 return 0xCAFE and port2 returns 0xBEEF.
